// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor
//   Watches a checkbit bus for the ordered signature sequence
//   SIG_BASE+0 .. SIG_BASE+N_CHK-1. Each value must be stable for STABLE_CYC
//   consecutive samples before it counts. Reports pass, or fail with a cause
//   code, together with the stage reached and the cycles used.
//   Optional feature macro: CHKMON_STAGE_TIMEOUT_EN (per-checkpoint cycle budget;
//   when undefined the budget covers the whole sequence from start_i).
module checkpoint_seq_monitor #(
  parameter int              CHK_W       = 16,
  parameter int              N_CHK       = 2,
  parameter logic [CHK_W-1:0] SIG_BASE   = 16'hAB60,
  parameter int              STABLE_CYC  = 2,
  parameter int              TIMEOUT_CYC = 70000,
  parameter int              CNT_W       = 17
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start_i,
  input  logic [CHK_W-1:0]           checkbits_i,
  output logic                       busy_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic [1:0]                 err_o,
  output logic [$clog2(N_CHK+1)-1:0] stage_o,
  output logic                       chk_pulse_o,
  output logic [CNT_W-1:0]           cycles_o
);

  localparam int STG_W = $clog2(N_CHK + 1);
  localparam int ST_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STABLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ORDER   = 2'b10
  } err_t;

  state_t             state, state_n;
  err_t               err_q, err_n;
  logic [STG_W-1:0]   stage_q, stage_n;
  logic [CNT_W-1:0]   cycles_q, cycles_n;
  logic               pass_q, pass_n;
  logic               fail_q, fail_n;
  logic               pulse_q, pulse_n;

  logic [CHK_W-1:0]   cb_q;
  logic [ST_W-1:0]    st_cnt;
  logic               same;
  logic               qualified;
  logic [CHK_W-1:0]   offset;
  logic               hit_cur;
  logic               hit_ahead;
  logic               budget_end;

  // st_cnt counts how many consecutive times the previous sample matched the
  // one before it, so the current value has been present for st_cnt+2 samples
  // when it equals cb_q. STABLE_CYC=1 qualifies every sample outright.
  assign same      = (checkbits_i == cb_q);
  assign qualified = (STABLE_CYC <= 1) || (same && (int'(st_cnt) + 2 >= STABLE_CYC));

  // Offset of the observed value within the signature window (wraps mod 2^CHK_W).
  assign offset     = checkbits_i - SIG_BASE;
  assign hit_cur    = qualified && (offset == CHK_W'(stage_q));
  assign hit_ahead  = qualified && (offset > CHK_W'(stage_q)) && (offset < CHK_W'(N_CHK));
  assign budget_end = (cycles_q == CNT_W'(TIMEOUT_CYC - 1));

  // Input sampler: previous sample and saturating stability counter.
  // NOTE: the sample register is cleared on reset so that the first
  // post-reset comparison is against a known value rather than X.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cb_q   <= '0;
      st_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      cb_q <= checkbits_i;
      if (!same)
        st_cnt <= '0;
      else if (st_cnt != ST_MAX)
        st_cnt <= st_cnt + 1'b1;
    end
  end

  // State and status registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      err_q    <= ERR_NONE;
      stage_q  <= '0;
      cycles_q <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_n;
      err_q    <= err_n;
      stage_q  <= stage_n;
      cycles_q <= cycles_n;
      pass_q   <= pass_n;
      fail_q   <= fail_n;
      pulse_q  <= pulse_n;
    end
  end

  // Next-state and status update: start wins, then match, out-of-order, timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_n  = state;
    err_n    = err_q;
    stage_n  = stage_q;
    cycles_n = cycles_q;
    pass_n   = pass_q;
    fail_n   = fail_q;
    pulse_n  = 1'b0;

    if (start_i) begin
      state_n  = ST_WAIT;
      err_n    = ERR_NONE;
      stage_n  = '0;
      cycles_n = '0;
      pass_n   = 1'b0;
      fail_n   = 1'b0;
    end else if (state == ST_WAIT) begin
      if (hit_cur) begin
        // A held signature advances only once: the expected value moves on.
        stage_n = stage_q + 1'b1;
        pulse_n = 1'b1;
`ifdef CHKMON_STAGE_TIMEOUT_EN
        cycles_n = '0;
`endif
        if (stage_n == STG_W'(N_CHK)) begin
          state_n = ST_PASS;
          pass_n  = 1'b1;
        end
      end else if (hit_ahead) begin
        state_n = ST_FAIL;
        fail_n  = 1'b1;
        err_n   = ERR_ORDER;
      end else if (budget_end) begin
        state_n = ST_FAIL;
        fail_n  = 1'b1;
        err_n   = ERR_TIMEOUT;
      end else begin
        cycles_n = cycles_q + 1'b1;
      end
    end
  end

  assign busy_o      = (state == ST_WAIT);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign err_o       = err_q;
  assign stage_o     = stage_q;
  assign chk_pulse_o = pulse_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: three instances (default, short budget,
// wrapping signatures with STABLE_CYC=1) compared every cycle against a
// run-length based reference model, plus directed spot checks.
module tb_checkpoint_seq_monitor;

  localparam int NI = 3;

  typedef struct {
    int n;
    int base;
    int stable;
    int timeout;
  } prm_t;

  // st: 0 idle, 1 waiting, 2 passed, 3 failed
  typedef struct {
    int st;
    int stage;
    int cycles;
    int err;
    bit pass;
    bit fail;
    bit pulse;
    int last;
    int run;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [NI];
  logic [15:0] cb    [NI];

  logic busy0, pass0, fail0, pulse0;
  logic [1:0] err0, stage0;
  logic [16:0] cyc0;
  logic busy1, pass1, fail1, pulse1;
  logic [1:0] err1, stage1;
  logic [3:0] cyc1;
  logic busy2, pass2, fail2, pulse2;
  logic [1:0] err2, stage2;
  logic [3:0] cyc2;

  prm_t prm [NI];
  mdl_t mdl [NI];
  int   hold [NI];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  checkpoint_seq_monitor u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[0]), .checkbits_i(cb[0]),
    .busy_o(busy0), .pass_o(pass0), .fail_o(fail0), .err_o(err0),
    .stage_o(stage0), .chk_pulse_o(pulse0), .cycles_o(cyc0)
  );

  checkpoint_seq_monitor #(
    .CHK_W(16), .N_CHK(2), .SIG_BASE(16'hAB60), .STABLE_CYC(2),
    .TIMEOUT_CYC(10), .CNT_W(4)
  ) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[1]), .checkbits_i(cb[1]),
    .busy_o(busy1), .pass_o(pass1), .fail_o(fail1), .err_o(err1),
    .stage_o(stage1), .chk_pulse_o(pulse1), .cycles_o(cyc1)
  );

  checkpoint_seq_monitor #(
    .CHK_W(16), .N_CHK(3), .SIG_BASE(16'hFFFF), .STABLE_CYC(1),
    .TIMEOUT_CYC(12), .CNT_W(4)
  ) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[2]), .checkbits_i(cb[2]),
    .busy_o(busy2), .pass_o(pass2), .fail_o(fail2), .err_o(err2),
    .stage_o(stage2), .chk_pulse_o(pulse2), .cycles_o(cyc2)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{st: 0, stage: 0, cycles: 0, err: 0, pass: 1'b0, fail: 1'b0,
          pulse: 1'b0, last: 0, run: 1};
    return m;
  endfunction

  // One clock of the reference model. A value qualifies once it has been
  // present for at least `stable` consecutive samples, this one included.
  function automatic mdl_t step(prm_t p, mdl_t m, bit s, int v);
    mdl_t r;
    int   run_now;
    int   k;
    bit   qual;
    r       = m;
    run_now = (v == m.last) ? m.run + 1 : 1;
    qual    = (run_now >= p.stable);
    r.last  = v;
    r.run   = run_now;
    r.pulse = 1'b0;
    k       = (v - p.base) & 16'hFFFF;
    if (s) begin
      r.st = 1; r.stage = 0; r.cycles = 0; r.err = 0; r.pass = 0; r.fail = 0;
    end else if (m.st == 1) begin
      if (qual && k == m.stage) begin
        r.stage = m.stage + 1;
        r.pulse = 1'b1;
`ifdef CHKMON_STAGE_TIMEOUT_EN
        r.cycles = 0;
`endif
        if (r.stage == p.n) begin
          r.st = 2; r.pass = 1'b1;
        end
      end else if (qual && k > m.stage && k < p.n) begin
        r.st = 3; r.fail = 1'b1; r.err = 2;
      end else if (m.cycles == p.timeout - 1) begin
        r.st = 3; r.fail = 1'b1; r.err = 1;
      end else begin
        r.cycles = m.cycles + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] pack(logic busy, logic pass, logic fail,
                                       logic [1:0] err, logic [31:0] stage,
                                       logic pulse, logic [31:0] cycles);
    return {18'b0, busy, pass, fail, err, stage[7:0], pulse, cycles};
  endfunction

  function automatic logic [63:0] obs_of(int i);
    case (i)
      0:       return pack(busy0, pass0, fail0, err0, 32'(stage0), pulse0, 32'(cyc0));
      1:       return pack(busy1, pass1, fail1, err1, 32'(stage1), pulse1, 32'(cyc1));
      default: return pack(busy2, pass2, fail2, err2, 32'(stage2), pulse2, 32'(cyc2));
    endcase
  endfunction

  function automatic logic [63:0] exp_of(int i);
    mdl_t m;
    m = mdl[i];
    return pack(m.st == 1, m.pass, m.fail, 2'(m.err), 32'(m.stage), m.pulse, 32'(m.cycles));
  endfunction

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_models(string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s_u%0d_c%0d", tag, i, cyc), obs_of(i), exp_of(i));
  endtask

  // Advance one clock: inputs already set; model follows the edge; compare 1 ns later.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++)
      mdl[i] = step(prm[i], mdl[i], start[i], int'(cb[i]));
    cyc++;
    #1;
    check_models("cyc");
    for (int i = 0; i < NI; i++)
      start[i] = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      mdl[i] = mdl_reset();
    check_models("arst");
    check("arst_u0_zero", obs_of(0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) until the model of instance i reports a given cycles_o value.
  task automatic run_until_cycles(int i, int target);
    for (int g = 0; g < 40 && mdl[i].cycles != target && mdl[i].st == 1; g++)
      tick();
  endtask

  task automatic scenario_pass_u0(string tag);
    start[0] = 1'b1; cb[0] = 16'h0000; tick();
    cb[0] = 16'hAB60; tick(); tick();
    check({tag, "_stage1"}, 64'({stage0, pulse0, pass0}), 64'({2'd1, 1'b1, 1'b0}));
    cb[0] = 16'hAB61; tick(); tick();
    check({tag, "_pass"}, 64'({pass0, fail0, err0, stage0, pulse0}),
          64'({1'b1, 1'b0, 2'b00, 2'd2, 1'b1}));
    cb[0] = 16'h0000; tick(); tick();
    check({tag, "_hold"}, 64'({pass0, busy0, stage0, pulse0}), 64'({1'b1, 1'b0, 2'd2, 1'b0}));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      cb[i]    = 16'h0000;
      hold[i]  = 0;
      mdl[i]   = mdl_reset();
    end
    prm[0] = '{n: 2, base: 16'hAB60, stable: 2, timeout: 70000};
    prm[1] = '{n: 2, base: 16'hAB60, stable: 2, timeout: 10};
    prm[2] = '{n: 3, base: 16'hFFFF, stable: 1, timeout: 12};

    // Reset state
    #12;
    check_models("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: in-order pass on the default instance
    scenario_pass_u0("s1");

    // 2: checkpoint 1 before checkpoint 0 -> out-of-order
    start[0] = 1'b1; cb[0] = 16'h0000; tick();
    cb[0] = 16'hAB61; tick(); tick();
    check("s2_order", 64'({fail0, err0, stage0}), 64'({1'b1, 2'b10, 2'd0}));
    cb[0] = 16'h0000; tick();

    // 3: a one-cycle glitch never qualifies; budget expires (TIMEOUT_CYC=10)
    start[1] = 1'b1; cb[1] = 16'h0000; tick();
    cb[1] = 16'hAB60; tick();
    cb[1] = 16'h0000;
    for (int g = 0; g < 30 && mdl[1].st == 1; g++) tick();
    check("s3_timeout", 64'({fail1, err1, stage1, cyc1}), 64'({1'b1, 2'b01, 2'd0, 4'd9}));

    // 4a: AB60 qualified at cycle 3, AB61 qualified exactly at cycle 9 -> pass
    start[1] = 1'b1; tick();
    run_until_cycles(1, 2);
    cb[1] = 16'hAB60; tick(); tick();
    cb[1] = 16'h0000;
    run_until_cycles(1, 8);
    cb[1] = 16'hAB61; tick(); tick();
    check("s4_edge_pass", 64'({pass1, fail1, err1}), 64'({1'b1, 1'b0, 2'b00}));
    cb[1] = 16'h0000; tick();

    // 4b: first advance late, second four cycles after it
    start[1] = 1'b1; tick();
    run_until_cycles(1, 6);
    cb[1] = 16'hAB60; tick(); tick();
    cb[1] = 16'h0000; tick(); tick(); tick();
    cb[1] = 16'hAB61; tick(); tick();
`ifdef CHKMON_STAGE_TIMEOUT_EN
    check("s4_stage_budget", 64'({pass1, fail1, err1}), 64'({1'b1, 1'b0, 2'b00}));
`else
    check("s4_seq_budget", 64'({pass1, fail1, err1}), 64'({1'b0, 1'b1, 2'b01}));
`endif
    cb[1] = 16'h0000; tick();

    // 5: reset mid-run after stage 1, then a fresh run passes
    start[0] = 1'b1; cb[0] = 16'h0000; tick();
    cb[0] = 16'hAB60; tick(); tick();
    check("s5_stage1", 64'(stage0), 64'd1);
    async_reset();
    scenario_pass_u0("s5");

    // 6: wrapping signatures FFFF, 0000, 0001 with STABLE_CYC=1
    start[2] = 1'b1; cb[2] = 16'h1234; tick();
    cb[2] = 16'hFFFF; tick();
    check("s6_stage1", 64'(stage2), 64'd1);
    cb[2] = 16'h0000; tick();
    cb[2] = 16'h0001; tick();
    check("s6_pass", 64'({pass2, stage2, err2}), 64'({1'b1, 2'd3, 2'b00}));
    cb[2] = 16'h1234; tick();

    // Randomized traffic against the model on all instances
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NI; i++) begin
        if (hold[i] == 0) begin
          if ($urandom_range(0, 3) != 0)
            cb[i] = 16'(prm[i].base + int'($urandom_range(0, prm[i].n)));
          else
            cb[i] = 16'($urandom);
          hold[i] = int'($urandom_range(1, 4));
        end
        hold[i]--;
        if ((mdl[i].st != 1 && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
          start[i] = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
